hist_stat_pp: RTL and testbench
===============================

// Module: hist_stat_pp
// PURPOSE
//  Ping-pong grey-level histogram engine for the hist_EQ pipeline. Accumulates one frame's histogram
//  into one RAM bank while the previous frame's bank is streamed out (per-bin or cumulative) and
//  cleared-on-read, so statistics of frame N+1 overlap readout of frame N. Feeds the equalisation LUT builder.
// PARAMETERS
//  DATA_W  8    grey bit width; bins = 2**DATA_W
//  H_DISP  800  valid pixels per line
//  V_DISP  600  lines per frame
//  CNT_W   21   bin/accumulator width; must satisfy 2**CNT_W > H_DISP*V_DISP
// PORTS
//  clk               in   1       system clock
//  rst               in   1       asynchronous, active-high reset
//  pre_img_vsync     in   1       frame sync; rising edge = frame start
//  pre_img_hsync     in   1       line sync (unused internally, kept for chain compatibility)
//  pre_img_valid     in   1       pixel qualifier
//  pre_img_gray      in   DATA_W  pixel grey level
//  pixel_level_data  out  DATA_W  bin index of current readout word
//  pixel_cnt_num     out  CNT_W   bin count (or running sum, see CONFIGURATION)
//  pixel_level_vld   out  1       readout word valid
//  pixel_level_sop   out  1       high with bin 0 word
//  pixel_level_eop   out  1       high with bin 2**DATA_W-1 word
//  frame_drop        out  1       1-cycle pulse: a frame was discarded (readout still busy)
//  frame_err         out  1       1-cycle pulse: vsync rose before H_DISP*V_DISP pixels
// BEHAVIOUR
//  - Reset: all outputs 0, fill bank=0, readout idle, armed=0, pixel counter=0; RAM contents assumed 0
//    (bench preloads or RTL clears both banks in 2**DATA_W cycles after reset, readout blocked meanwhile).
//  - Accept: pixel accumulated only when pre_img_valid && armed. armed set on vsync rising edge
//    (registered edge detect, 1-cycle delay) if readout not holding the swap; cleared on frame close.
//  - Accumulate: 2-stage read-modify-write on fill bank (sync RAM, 1-cycle read). Forwarding mandatory:
//    back-to-back equal grey values (incl. every pixel identical) must count exactly; no stall, no loss.
//  - Frame close: pixel counter reaches H_DISP*V_DISP (last pixel), or vsync rises with counter!=0
//    (then frame_err pulses, partial frame closed normally). Counter resets on close and on vsync rise.
//  - Swap: on close, after RMW pipe drains (2 cycles), if readout idle -> fill bank toggles, readout
//    starts on old bank. If readout busy -> frame_drop pulses once, swap deferred until readout ends,
//    pixels of the closed frame's successor not accumulated until next vsync rise after the swap.
//  - Readout FSM: IDLE -> RUN (addr 0..2**DATA_W-1, one per cycle) -> IDLE. Read latency 2 cycles:
//    pixel_level_vld high for exactly 2**DATA_W consecutive cycles, starting 2 cycles after RUN entry.
//    Each bin written to 0 in the read bank on the cycle after its read (clear-on-read).
//  - pixel_level_data = bin index, increments by 1, wraps never within a burst.
//  - Width: bins saturate at 2**CNT_W-1 (never wrap); running sum saturates likewise.
//  - vsync rise during readout: does not disturb readout; new frame accumulates in the other bank.
//  - Reset mid-operation: immediate return to reset state; partial burst abandoned, vld drops same cycle.
// CONFIGURATION
//  HIST_CUM_EN defined: pixel_cnt_num = cumulative sum of bins 0..pixel_level_data (CDF);
//    eop word equals total pixels of the frame. Accumulator zeroed at sop.
//  HIST_CUM_EN undefined: pixel_cnt_num = count of bin pixel_level_data only; no running adder.
// TESTING  (DATA_W=8, H_DISP=4, V_DISP=2 unless stated)
//  1 Frame of 8 pixels all grey 7 -> burst of 256 vld, bin7=8, others 0; CUM: bins 7..255 = 8.
//  2 Grey seq 0,1,2,3,3,3,255,0 -> per-bin: b0=2,b1=1,b2=1,b3=3,b255=1; sop at bin0, eop at bin255.
//  3 Two frames back-to-back, H_DISP=400,V_DISP=1 -> two full bursts, second matches frame 2 only
//    (clear-on-read verified), frame_drop=0.
//  4 Frame 2 ends (H_DISP=4,V_DISP=2) while burst 1 running -> frame_drop 1 pulse, frame 3 reported correct.
//  5 vsync rises after 5 pixels -> frame_err pulse, burst reports those 5 pixels, next frame clean.
//  6 Assert rst at bin 100 of burst -> vld=0 next edge, all outputs 0, following frame counts exactly.

Source files
------------

// File: rtl/hist_stat_pp_if.sv
// Pixel-in / histogram-out signal bundle for hist_stat_pp.
// The master modport drives pixels and receives readout words; the slave modport is the engine side.
interface hist_stat_pp_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 21
) ();
  logic              pre_img_vsync;
  logic              pre_img_hsync;
  logic              pre_img_valid;
  logic [DATA_W-1:0] pre_img_gray;
  logic [DATA_W-1:0] pixel_level_data;
  logic [CNT_W-1:0]  pixel_cnt_num;
  logic              pixel_level_vld;
  logic              pixel_level_sop;
  logic              pixel_level_eop;
  logic              frame_drop;
  logic              frame_err;

  modport master (
    output pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_gray,
    input  pixel_level_data, pixel_cnt_num, pixel_level_vld,
    input  pixel_level_sop, pixel_level_eop, frame_drop, frame_err
  );

  modport slave (
    input  pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_gray,
    output pixel_level_data, pixel_cnt_num, pixel_level_vld,
    output pixel_level_sop, pixel_level_eop, frame_drop, frame_err
  );
endinterface

// File: rtl/hist_stat_pp.sv
// Ping-pong grey-level histogram: one bank accumulates while the other streams out and clears on read.
// Define HIST_CUM_EN to emit the running sum (CDF) instead of per-bin counts.
//   state   | meaning
//   RO_IDLE | no burst; waiting for a bank swap to start readout
//   RO_RUN  | issuing read addresses 0..2**DATA_W-1, one per cycle
module hist_stat_pp #(
  parameter int DATA_W = 8,
  parameter int H_DISP = 800,
  parameter int V_DISP = 600,
  parameter int CNT_W  = 21
) (
  input logic           clk,
  input logic           rst,
  hist_stat_pp_if.slave bus
);
  localparam int BINS  = 2**DATA_W;
  localparam int TOTAL = H_DISP * V_DISP;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(TOTAL - 1);
  localparam logic [DATA_W-1:0] LAST_BIN = '1;
  localparam logic [0:0] RO_IDLE = 1'b0;
  localparam logic [0:0] RO_RUN  = 1'b1;

  logic [CNT_W-1:0]  mem   [2][BINS];
  logic [CNT_W-1:0]  rdata [2];
  logic [DATA_W-1:0] rd_addr [2];
  logic              we    [2];
  logic [DATA_W-1:0] waddr [2];
  logic [CNT_W-1:0]  wdata [2];

  logic              vs_q, vs_d;
  logic              armed_q, armed_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              fill_bank_q, fill_bank_d;
  logic              defer_q, defer_d;
  logic [1:0]        start_q, start_d;
  logic              init_q, init_d;
  logic [DATA_W-1:0] init_addr_q, init_addr_d;
  logic              s1_v_q, s1_v_d;
  logic [DATA_W-1:0] s1_addr_q, s1_addr_d;
  logic              s1_bank_q, s1_bank_d;
  logic              wb_v_q, wb_v_d;
  logic [DATA_W-1:0] wb_addr_q, wb_addr_d;
  logic              wb_bank_q, wb_bank_d;
  logic [CNT_W-1:0]  wb_data_q, wb_data_d;
  logic [0:0]        ro_state_q, ro_state_d;
  logic [DATA_W-1:0] ro_addr_q, ro_addr_d;
  logic              ro_s1_v_q, ro_s1_v_d;
  logic [DATA_W-1:0] ro_s1_addr_q, ro_s1_addr_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic              drop_q, drop_d;
  logic              err_q, err_d;
`ifdef HIST_CUM_EN
  logic [CNT_W-1:0]  cum_q, cum_d;
  logic [CNT_W:0]    sum_ext;
  logic [CNT_W-1:0]  run_sum;
`endif

  logic             vs_rise, ro_busy, accept, last_px, err_close, close, swap, ro_bank;
  logic [CNT_W-1:0] base, inc, bin;
  logic             hsync_unused;

  assign hsync_unused = bus.pre_img_hsync;
  assign ro_bank      = ~fill_bank_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (we[b]) mem[b][waddr[b]] <= wdata[b];
      rdata[b] <= mem[b][rd_addr[b]];
    end
  end

  // Frame bookkeeping; the fill bank flips at close and readout trails by two cycles so the RMW pipe drains first.
  always_comb begin
    vs_rise   = bus.pre_img_vsync & ~vs_q;
    ro_busy   = (ro_state_q == RO_RUN) | ro_s1_v_q | (|start_q);
    accept    = bus.pre_img_valid & armed_q & ~vs_rise;
    last_px   = accept & (pix_cnt_q == LAST_PIX);
    err_close = vs_rise & (pix_cnt_q != '0);
    close     = last_px | err_close;
    swap      = (close | defer_q) & ~ro_busy;

    vs_d    = bus.pre_img_vsync;
    armed_d = armed_q;
    if (last_px) armed_d = 1'b0;
    if (vs_rise) armed_d = ~init_q & ~defer_q & ~(err_close & ro_busy);

    pix_cnt_d = pix_cnt_q;
    if (close || vs_rise) pix_cnt_d = '0;
    else if (accept)      pix_cnt_d = pix_cnt_q + CNT_W'(1);

    defer_d     = (close | defer_q) & ro_busy;
    fill_bank_d = fill_bank_q ^ swap;
    start_d     = {start_q[0], swap};
    drop_d      = close & ro_busy;
    err_d       = err_close;

    init_d      = init_q & (init_addr_q != LAST_BIN);
    init_addr_d = init_q ? init_addr_q + DATA_W'(1) : init_addr_q;
  end

  // Read-modify-write with one-deep forwarding of the value written on the same edge as our read.
  always_comb begin
    s1_v_d    = accept;
    s1_addr_d = bus.pre_img_gray;
    s1_bank_d = fill_bank_q;
    if (wb_v_q && (wb_addr_q == s1_addr_q) && (wb_bank_q == s1_bank_q)) base = wb_data_q;
    else                                                                 base = rdata[s1_bank_q];
    inc       = (base == CNT_MAX) ? base : base + CNT_W'(1);
    wb_v_d    = s1_v_q;
    wb_addr_d = s1_addr_q;
    wb_bank_d = s1_bank_q;
    wb_data_d = inc;
  end

  always_comb begin
    ro_state_d = ro_state_q;
    ro_addr_d  = ro_addr_q;
    case (ro_state_q)
      RO_IDLE: begin
        if (start_q[1]) begin
          ro_state_d = RO_RUN;
          ro_addr_d  = '0;
        end
      end
      RO_RUN: begin
        ro_addr_d = ro_addr_q + DATA_W'(1);
        if (ro_addr_q == LAST_BIN) ro_state_d = RO_IDLE;
      end
      default: ro_state_d = RO_IDLE;
    endcase
    ro_s1_v_d    = (ro_state_q == RO_RUN);
    ro_s1_addr_d = ro_addr_q;
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      rd_addr[b] = (ro_bank == 1'(b)) ? ro_addr_q : bus.pre_img_gray;
      we[b]      = 1'b0;
      waddr[b]   = '0;
      wdata[b]   = '0;
      if (init_q) begin
        we[b]    = 1'b1;
        waddr[b] = init_addr_q;
      end else if (s1_v_q && (s1_bank_q == 1'(b))) begin
        we[b]    = 1'b1;
        waddr[b] = s1_addr_q;
        wdata[b] = inc;
      end else if (ro_s1_v_q && (ro_bank == 1'(b))) begin
        we[b]    = 1'b1;
        waddr[b] = ro_s1_addr_q;
      end
    end
  end

  always_comb begin
    bin    = rdata[ro_bank];
    vld_d  = ro_s1_v_q;
    data_d = ro_s1_v_q ? ro_s1_addr_q : '0;
    sop_d  = ro_s1_v_q & (ro_s1_addr_q == '0);
    eop_d  = ro_s1_v_q & (ro_s1_addr_q == LAST_BIN);
`ifdef HIST_CUM_EN
    sum_ext = {1'b0, cum_q} + {1'b0, bin};
    if (ro_s1_addr_q == '0) run_sum = bin;
    else                    run_sum = sum_ext[CNT_W] ? CNT_MAX : sum_ext[CNT_W-1:0];
    cum_d = ro_s1_v_q ? run_sum : cum_q;
    cnt_d = ro_s1_v_q ? run_sum : '0;
`else
    cnt_d = ro_s1_v_q ? bin : '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q         <= 1'b0;
      armed_q      <= 1'b0;
      pix_cnt_q    <= '0;
      fill_bank_q  <= 1'b0;
      defer_q      <= 1'b0;
      start_q      <= '0;
      init_q       <= 1'b1;
      init_addr_q  <= '0;
      s1_v_q       <= 1'b0;
      s1_addr_q    <= '0;
      s1_bank_q    <= 1'b0;
      wb_v_q       <= 1'b0;
      wb_addr_q    <= '0;
      wb_bank_q    <= 1'b0;
      wb_data_q    <= '0;
      ro_state_q   <= RO_IDLE;
      ro_addr_q    <= '0;
      ro_s1_v_q    <= 1'b0;
      ro_s1_addr_q <= '0;
      vld_q        <= 1'b0;
      data_q       <= '0;
      cnt_q        <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      drop_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef HIST_CUM_EN
      cum_q        <= '0;
`endif
    end else begin
      vs_q         <= vs_d;
      armed_q      <= armed_d;
      pix_cnt_q    <= pix_cnt_d;
      fill_bank_q  <= fill_bank_d;
      defer_q      <= defer_d;
      start_q      <= start_d;
      init_q       <= init_d;
      init_addr_q  <= init_addr_d;
      s1_v_q       <= s1_v_d;
      s1_addr_q    <= s1_addr_d;
      s1_bank_q    <= s1_bank_d;
      wb_v_q       <= wb_v_d;
      wb_addr_q    <= wb_addr_d;
      wb_bank_q    <= wb_bank_d;
      wb_data_q    <= wb_data_d;
      ro_state_q   <= ro_state_d;
      ro_addr_q    <= ro_addr_d;
      ro_s1_v_q    <= ro_s1_v_d;
      ro_s1_addr_q <= ro_s1_addr_d;
      vld_q        <= vld_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      drop_q       <= drop_d;
      err_q        <= err_d;
`ifdef HIST_CUM_EN
      cum_q        <= cum_d;
`endif
    end
  end

  assign bus.pixel_level_vld  = vld_q;
  assign bus.pixel_level_data = data_q;
  assign bus.pixel_cnt_num    = cnt_q;
  assign bus.pixel_level_sop  = sop_q;
  assign bus.pixel_level_eop  = eop_q;
  assign bus.frame_drop       = drop_q;
  assign bus.frame_err        = err_q;
endmodule

// File: tb/tb_hist_stat_pp.sv
// Directed bench for hist_stat_pp (8-bit grey, 4x2 frames); covers per-bin and HIST_CUM_EN builds.
module tb_hist_stat_pp;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 21;
  localparam int H_DISP = 4;
  localparam int V_DISP = 2;
`ifdef HIST_CUM_EN
  localparam bit CUM = 1'b1;
`else
  localparam bit CUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  hist_stat_pp_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  hist_stat_pp #(.DATA_W(DATA_W), .H_DISP(H_DISP), .V_DISP(V_DISP), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tot_vld = 0, n_sop = 0, n_eop = 0, n_seq = 0, n_drop = 0, n_err = 0;
  int b_vld, b_sop, b_eop, b_seq;
  logic       prev_vld = 1'b0;
  logic [7:0] prev_data = '0;
  logic [CNT_W-1:0] cap [256];

  // Burst monitor: captures words and counts any break in the 0..255 sequence or misplaced sop/eop.
  always @(negedge clk) begin
    if (rst) begin
      prev_vld <= 1'b0;
    end else begin
      if (bus.pixel_level_vld) begin
        cap[bus.pixel_level_data] <= bus.pixel_cnt_num;
        tot_vld <= tot_vld + 1;
      end
      n_seq <= n_seq
        + int'(bus.pixel_level_vld && prev_vld && (prev_data == 8'd255 || bus.pixel_level_data != prev_data + 8'd1))
        + int'(bus.pixel_level_vld && !prev_vld && bus.pixel_level_data != 8'd0)
        + int'(!bus.pixel_level_vld && prev_vld && prev_data != 8'd255)
        + int'(bus.pixel_level_sop && !(bus.pixel_level_vld && bus.pixel_level_data == 8'd0))
        + int'(bus.pixel_level_eop && !(bus.pixel_level_vld && bus.pixel_level_data == 8'd255));
      n_sop  <= n_sop + int'(bus.pixel_level_sop);
      n_eop  <= n_eop + int'(bus.pixel_level_eop);
      n_drop <= n_drop + int'(bus.frame_drop);
      n_err  <= n_err + int'(bus.frame_err);
      prev_vld  <= bus.pixel_level_vld;
      prev_data <= bus.pixel_level_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    tick();
    bus.pre_img_vsync = 1'b1;
    tick();
    tick();
    bus.pre_img_vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_pix(input logic [7:0] px[$]);
    foreach (px[i]) begin
      bus.pre_img_valid = 1'b1;
      bus.pre_img_gray  = px[i];
      bus.pre_img_hsync = (i % H_DISP) < 2;
      tick();
    end
    bus.pre_img_valid = 1'b0;
    bus.pre_img_hsync = 1'b0;
  endtask

  task automatic mark();
    b_vld = tot_vld;
    b_sop = n_sop;
    b_eop = n_eop;
    b_seq = n_seq;
  endtask

  task automatic wait_check(input string tag, input logic [7:0] px[$], input int key);
    int n = 0;
    int e [256];
    int run = 0;
    int mism = 0;
    while ((tot_vld - b_vld) < 256 && n < 2000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk({tag, "_cnt"}, 64'(tot_vld - b_vld), 64'd256);
    foreach (e[i]) e[i] = 0;
    foreach (px[i]) e[px[i]]++;
    if (CUM) begin
      for (int i = 0; i < 256; i++) begin
        run += e[i];
        e[i] = run;
      end
    end
    for (int i = 0; i < 256; i++) if (cap[i] !== CNT_W'(e[i])) mism++;
    chk({tag, "_bins"}, 64'(mism), 64'd0);
    chk({tag, "_key"}, 64'(cap[key]), 64'(e[key]));
    chk({tag, "_sop"}, 64'(n_sop - b_sop), 64'd1);
    chk({tag, "_eop"}, 64'(n_eop - b_eop), 64'd1);
    chk({tag, "_seq"}, 64'(n_seq - b_seq), 64'd0);
  endtask

  logic [7:0] q1[$], q2[$], q3[$];
  int n;
  bit hit;

  initial begin
    bus.pre_img_vsync = 1'b0;
    bus.pre_img_hsync = 1'b0;
    bus.pre_img_valid = 1'b0;
    bus.pre_img_gray  = '0;
    repeat (3) tick();
    chk("rst_vld", 64'(bus.pixel_level_vld), 64'd0);
    chk("rst_outs", 64'({bus.pixel_level_data, bus.pixel_cnt_num, bus.pixel_level_sop,
                         bus.pixel_level_eop, bus.frame_drop, bus.frame_err}), 64'd0);
    rst = 1'b0;
    repeat (300) tick();

    // all pixels identical
    q1 = '{7, 7, 7, 7, 7, 7, 7, 7};
    mark(); vs_pulse(); send_pix(q1);
    wait_check("t1", q1, 7);
    chk("t1_b6", 64'(cap[6]), 64'd0);
    chk("t1_b255", 64'(cap[255]), CUM ? 64'd8 : 64'd0);
    repeat (10) tick();

    q1 = '{0, 1, 2, 3, 3, 3, 255, 0};
    mark(); vs_pulse(); send_pix(q1);
    wait_check("t2", q1, 3);
    chk("t2_b0", 64'(cap[0]), 64'd2);
    chk("t2_b7", 64'(cap[7]), CUM ? 64'd7 : 64'd0);
    chk("t2_b255", 64'(cap[255]), CUM ? 64'd8 : 64'd1);
    repeat (10) tick();

    q1 = '{10, 10, 10, 10, 20, 20, 20, 20};
    mark(); vs_pulse(); send_pix(q1);
    wait_check("t3", q1, 20);
    chk("t3_drop", 64'(n_drop), 64'd0);
    repeat (10) tick();

    // second frame closes while the first burst is still streaming
    q1 = '{50, 50, 50, 50, 51, 51, 51, 51};
    q2 = '{60, 60, 60, 60, 60, 60, 60, 60};
    q3 = '{1, 2, 3, 4, 5, 6, 7, 8};
    mark(); vs_pulse(); send_pix(q1);
    n = 0;
    while ((tot_vld - b_vld) < 20 && n < 1000) begin tick(); n++; end
    vs_pulse(); send_pix(q2);
    wait_check("t4a", q1, 51);
    chk("t4_drop", 64'(n_drop), 64'd1);
    mark();
    wait_check("t4b", q2, 60);
    repeat (10) tick();
    mark(); vs_pulse(); send_pix(q3);
    wait_check("t4c", q3, 5);
    chk("t4_drop_once", 64'(n_drop), 64'd1);
    repeat (10) tick();

    // short frame terminated by vsync
    q1 = '{9, 9, 100, 101, 9};
    mark(); vs_pulse(); send_pix(q1);
    repeat (3) tick();
    vs_pulse();
    wait_check("t5a", q1, 9);
    chk("t5_err", 64'(n_err), 64'd1);
    repeat (10) tick();
    q2 = '{33, 33, 33, 33, 33, 33, 33, 33};
    mark(); vs_pulse(); send_pix(q2);
    wait_check("t5b", q2, 33);
    chk("t5_err_clean", 64'(n_err), 64'd1);
    repeat (10) tick();

    // reset in the middle of a burst
    q1 = '{77, 77, 77, 77, 77, 77, 77, 77};
    mark(); vs_pulse(); send_pix(q1);
    n = 0;
    hit = 1'b0;
    while (!hit && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
      hit = bus.pixel_level_vld && (bus.pixel_level_data == 8'd100);
    end
    chk("t6_hit", 64'(hit), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_vld", 64'(bus.pixel_level_vld), 64'd0);
    chk("t6_outs", 64'({bus.pixel_level_data, bus.pixel_cnt_num, bus.pixel_level_sop,
                        bus.pixel_level_eop, bus.frame_drop, bus.frame_err}), 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (300) tick();
    q2 = '{3, 3, 3, 3, 3, 3, 3, 3};
    mark(); vs_pulse(); send_pix(q2);
    wait_check("t6b", q2, 3);
    chk("t6_b77", 64'(cap[77]), CUM ? 64'd8 : 64'd0);

    repeat (10) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
